// File: rtl/rr_arbiter4.sv
// 4-way arbiter, round-robin (fixed priority when ARB_FIXED_PRIO_EN is defined), owner hold bounded by MAX_HOLD.
// Latency: req sampled at edge t, registered gnt/gnt_idx/gnt_valid/preempt visible after that edge.
// Backpressure: requesters hold req until served; the owner is preempted after MAX_HOLD cycles if others wait.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       preempt
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [3:0]       gnt_d;
   logic [1:0]       idx_d;
   logic             vld_d;
   logic             pre_d;
   logic [CNT_W-1:0] hold_cnt, cnt_d;
   logic [3:0]       others;
   logic [1:0]       base;
   logic [1:0]       win_req;
   logic [1:0]       win_oth;

   // First set bit of r, scanning upward from base with mod-4 wrap.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = start + i[1:0];
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

`ifdef ARB_FIXED_PRIO_EN
   assign base = 2'd0;
`else
   logic [1:0] last_idx;

   assign base = last_idx + 2'd1;

   // While busy, idx_d equals the current owner, so this tracks each new grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_idx <= 2'b11;
      end else if (vld_d) begin
         last_idx <= idx_d;
      end
   end
`endif

   assign others  = req & ~gnt;
   assign win_req = pick(req, base);
   assign win_oth = pick(others, base);

   always_comb begin
      state_d = state_q;
      idx_d   = gnt_idx;
      cnt_d   = hold_cnt;
      pre_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               idx_d   = win_req;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (!req[gnt_idx]) begin
               // Release wins over a coincident hold expiry: no preempt pulse.
               cnt_d = '0;
               if (|req) begin
                  idx_d = win_req;
               end else begin
                  state_d = IDLE;
                  idx_d   = 2'd0;
               end
            end else if (|others && hold_cnt == HOLD_LAST) begin
               idx_d = win_oth;
               cnt_d = '0;
               pre_d = 1'b1;
            end else if (hold_cnt != HOLD_LAST) begin
               cnt_d = hold_cnt + 1'b1;
            end
         end
      endcase
      vld_d = (state_d == BUSY);
      gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt       <= 4'b0000;
         gnt_idx   <= 2'b00;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         gnt       <= gnt_d;
         gnt_idx   <= idx_d;
         gnt_valid <= vld_d;
         preempt   <= pre_d;
         hold_cnt  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single request, round-robin order,
// MAX_HOLD preemption, release at expiry, async reset mid-grant.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int total = 0;
   int bad   = 0;

   rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                          input logic ev, input logic ep);
      chk({tag, ".gnt"},   {4'b0, gnt},       {4'b0, eg});
      chk({tag, ".idx"},   {6'b0, gnt_idx},   {6'b0, ei});
      chk({tag, ".vld"},   {7'b0, gnt_valid}, {7'b0, ev});
      chk({tag, ".pre"},   {7'b0, preempt},   {7'b0, ep});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      #2;
      rst_n = 1'b1;
   endtask

   logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [1:0] rr_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      // reset held with all requests up
      #1;
      chk_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      req   = 4'b0000;
      step();
      chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // single request
      req = 4'b0100;
      #1;
      chk_out("single_pre_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("single", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      chk_out("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_FIXED_PRIO_EN
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req = 4'b1001;
         step();
         chk_out($sformatf("fp_win%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
         req = 4'b0000;
         step();
         chk_out($sformatf("fp_idle%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      req = 4'b1001;
      step();
      chk_out("fp_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b1000;
      step();
      chk_out("fp_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
`else
      // round-robin: each owner drops req for one cycle after two grant cycles
      do_reset();
      req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         chk_out($sformatf("rr%0d_c1", k), rr_gnt[k], rr_idx[k], 1'b1, 1'b0);
         req = 4'b1111;
         step();
         chk_out($sformatf("rr%0d_c2", k), rr_gnt[k], rr_idx[k], 1'b1, 1'b0);
         req = 4'b1111 & ~rr_gnt[k];
         step();
      end

      // preemption: req0 held, req2 raised after cycle 3
      do_reset();
      req = 4'b0001;
      for (int n = 1; n <= 24; n++) begin
         step();
         if (n == 3) req = 4'b0101;
         if (n <= 8 || n >= 17)
            chk_out($sformatf("pre_n%0d", n), 4'b0001, 2'd0, 1'b1, (n == 17));
         else
            chk_out($sformatf("pre_n%0d", n), 4'b0100, 2'd2, 1'b1, (n == 9));
      end
      // owner 0 is at its last hold cycle; drop it at the same time
      req = 4'b0100;
      step();
      chk_out("rel_at_expiry", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

      // async reset mid-grant
      do_reset();
      req = 4'b0010;
      step();
      chk_out("ar_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("ar_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1010;
      #2;
      rst_n = 1'b1;
      #1;
      chk_out("ar_released", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("ar_resume", 4'b0010, 2'd1, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
